// File: rtl/gpu_scanout.sv
// Raster scanout that reads 1-bpp screen words through a single-outstanding read port
// and turns them into 24-bit pixels, reporting underflow when a word has not arrived in time.
module gpu_scanout #(
  parameter int          WIDTH        = 640,
  parameter int          HEIGHT       = 480,
  parameter int          ACTIVE_W     = 512,
  parameter int          ACTIVE_H     = 256,
  parameter int          WORD_W       = 16,
  parameter int          ADDR_W       = 15,
  parameter int          BASE         = 16384,
  parameter logic [23:0] FG_COLOR     = 24'h000000,
  parameter logic [23:0] BG_COLOR     = 24'hffffff,
  parameter logic [23:0] BORDER_COLOR = 24'h000000,
  parameter logic [23:0] UNDER_COLOR  = 24'hff0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_newframe,
  input  logic              i_enable,
  input  logic              i_test,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_ack,
  input  logic              i_rd_valid,
  input  logic [WORD_W-1:0] i_rd_data,
  output logic              o_underflow,
  output logic [23:0]       pixel
);
  localparam int XW   = $clog2(WIDTH);
  localparam int YW   = $clog2(HEIGHT + 1);
  localparam int BW   = $clog2(WORD_W);
  localparam int COLS = ACTIVE_W / WORD_W;
  localparam int CW   = $clog2(COLS + 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [XW-1:0] X_ACT  = XW'(ACTIVE_W);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic [YW-1:0] Y_ACT  = YW'(ACTIVE_H);
  localparam logic [CW-1:0] C_END  = CW'(COLS);
  localparam logic [BW-1:0] B_LAST = BW'(WORD_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state, state_n;

  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [WORD_W-1:0] cur, nxt;
  logic              cur_v, nxt_v;
  logic [YW-1:0]     row;
  logic [CW-1:0]     col;
  logic              armed, drop;
  logic              in_active, advance, trigger, flush, fill, go;
  logic              cur_v_adv, nxt_v_adv;
  logic [YW-1:0]     nxt_row;

  assign in_active = (x < X_ACT) && (y < Y_ACT);
  assign advance   = i_enable && in_active && (x[BW-1:0] == B_LAST);
  assign trigger   = i_enable && (x == X_ACT);
  assign flush     = i_newframe || trigger;
  assign nxt_row   = (y == Y_LAST) ? '0 : y + 1'b1;
  // Buffer view after this cycle's advance; fills and the slot-free test use it.
  assign cur_v_adv = advance ? nxt_v : cur_v;
  assign nxt_v_adv = advance ? 1'b0 : nxt_v;
  assign fill      = (state == S_WAIT) && i_rd_valid && !drop && !flush;
  assign go        = armed && !flush && !nxt_v_adv && (col < C_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (i_newframe) begin
      x <= '0;
      y <= '0;
    end else if (i_enable) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur   <= '0;
      nxt   <= '0;
      cur_v <= 1'b0;
      nxt_v <= 1'b0;
    end else if (flush) begin
      cur_v <= 1'b0;
      nxt_v <= 1'b0;
    end else begin
      if (advance) cur <= nxt;
      cur_v <= cur_v_adv;
      nxt_v <= nxt_v_adv;
      if (fill) begin
        if (!cur_v_adv) begin
          cur   <= i_rd_data;
          cur_v <= 1'b1;
        end else begin
          nxt   <= i_rd_data;
          nxt_v <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row   <= '0;
      col   <= '0;
      armed <= 1'b1;
    end else if (i_newframe) begin
      row   <= '0;
      col   <= '0;
      armed <= 1'b1;
    end else if (trigger) begin
      row   <= nxt_row;
      col   <= '0;
      armed <= (nxt_row < Y_ACT);
    end else if (state == S_REQ && i_rd_ack) begin
      col <= col + 1'b1;
    end
  end

  // A flushed transaction still runs to completion; drop marks its data as stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      drop <= 1'b0;
    else if (flush)
      drop <= (state == S_REQ) || (state == S_WAIT && !i_rd_valid);
    else if (state == S_WAIT && i_rd_valid)
      drop <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      o_rd_addr <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && go)
        o_rd_addr <= ADDR_W'(BASE) + ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (go) state_n = S_REQ;
      S_REQ:   if (i_rd_ack) state_n = S_WAIT;
      S_WAIT:  if (i_rd_valid) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign o_rd_req = (state == S_REQ);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      o_underflow <= 1'b0;
    else if (i_newframe)
      o_underflow <= 1'b0;
    else if (i_enable && in_active && !i_test && !cur_v)
      o_underflow <= 1'b1;
  end

  always_comb begin
    pixel = BORDER_COLOR;
    if (in_active) begin
      if (i_test)
        pixel = (x[3] ^ y[3]) ? FG_COLOR : BG_COLOR;
      else if (!cur_v)
        pixel = UNDER_COLOR;
      else
        pixel = cur[x[BW-1:0]] ? FG_COLOR : BG_COLOR;
    end
  end
endmodule

// File: tb/tb_gpu_scanout.sv
// Directed bench for gpu_scanout: latency-2 memory returning data=address, raster tracked
// locally so pixel and request expectations can be checked at known (X,Y) points.
module tb_gpu_scanout;
  localparam int ADDR_W = 15;
  localparam int WORD_W = 16;
  localparam int LIM    = 20000;

  logic              clk = 1'b0;
  logic              rst;
  logic              newframe, enable, tst;
  logic              rd_req, rd_ack, rd_valid;
  logic [ADDR_W-1:0] rd_addr;
  logic [WORD_W-1:0] rd_data;
  logic              underflow;
  logic [23:0]       pixel;

  logic              ack_en, data_ones;
  logic              p1, p2;
  logic [ADDR_W-1:0] a1, a2;
  logic [ADDR_W-1:0] log_mem [0:4095];
  int                log_n, base;
  int                tx, ty;
  int                checks, failures;

  gpu_scanout #(.HEIGHT(20), .ACTIVE_H(16)) dut (
    .clk(clk), .rst(rst), .i_newframe(newframe), .i_enable(enable), .i_test(tst),
    .o_rd_req(rd_req), .o_rd_addr(rd_addr), .i_rd_ack(rd_ack), .i_rd_valid(rd_valid),
    .i_rd_data(rd_data), .o_underflow(underflow), .pixel(pixel)
  );

  always #5 clk = ~clk;

  assign rd_ack   = rd_req & ack_en;
  assign rd_valid = p2;
  assign rd_data  = data_ones ? 16'hffff : {1'b0, a2};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p1 <= 1'b0; p2 <= 1'b0; a1 <= '0; a2 <= '0; log_n <= 0;
    end else begin
      p1 <= rd_req && rd_ack;
      a1 <= rd_addr;
      p2 <= p1;
      a2 <= a1;
      if (rd_req && rd_ack) begin
        log_mem[log_n[11:0]] <= rd_addr;
        log_n <= log_n + 1;
      end
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tx <= 0; ty <= 0;
    end else if (newframe) begin
      tx <= 0; ty <= 0;
    end else if (enable) begin
      if (tx == 639) begin
        tx <= 0;
        ty <= (ty == 19) ? 0 : ty + 1;
      end else tx <= tx + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (base + i < log_n) ? {17'd0, log_mem[(base + i) % 4096]} : 32'hffffffff;
  endfunction

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic run_to(input int x, input int y, input bit tog);
    int n = 0;
    if (!tog) enable = 1'b1;
    while (!(tx == x && ty == y) && n < LIM) begin
      if (tog) enable = ~enable;
      @(posedge clk); #1;
      n++;
    end
    if (n >= LIM) chk("reach_timeout", n, 0);
  endtask

  task automatic pulse_nf(input logic en);
    enable = en; newframe = 1'b1;
    step(1);
    newframe = 1'b0;
    base = log_n;
  endtask

  initial begin
    int n;
    checks = 0; failures = 0; base = 0;
    rst = 1'b1; newframe = 0; enable = 0; tst = 0; ack_en = 1; data_ones = 0;
    step(3);
    chk("rst_req", rd_req, 0);
    chk("rst_uf", underflow, 0);
    chk("rst_px", pixel, 24'hff0000);
    rst = 1'b0;
    step(5);

    // Basic fetch and shift-out of row 0
    pulse_nf(0);
    step(12);
    chk("addr0", log_at(0), 16384);
    chk("addr1", log_at(1), 16385);
    run_to(0, 0, 0);  chk("px_0_0", pixel, 24'hffffff);
    run_to(14, 0, 0); chk("px_14_0", pixel, 24'h000000);
    run_to(15, 0, 0); chk("px_15_0", pixel, 24'hffffff);
    run_to(16, 0, 0); chk("px_16_0", pixel, 24'h000000);
    run_to(17, 0, 0); chk("px_17_0", pixel, 24'hffffff);
    run_to(512, 0, 0);
    chk("px_border", pixel, 24'h000000);
    chk("uf_row0", underflow, 0);
    base = log_n;
    run_to(540, 0, 0); chk("addr_row1", log_at(0), 16416);
    run_to(512, 15, 0); base = log_n;
    run_to(639, 15, 0); chk("no_req_last", log_n - base, 0);
    run_to(512, 19, 0); base = log_n;
    run_to(540, 19, 0); chk("addr_wrap", log_at(0), 16384);
    run_to(0, 0, 0);  chk("px_wrap_0", pixel, 24'hffffff);
    run_to(14, 0, 0); chk("px_wrap_14", pixel, 24'h000000);
    chk("uf_wrap", underflow, 0);

    // Starved read port
    run_to(100, 0, 0);
    ack_en = 0;
    pulse_nf(1);
    chk("under_px", pixel, 24'hff0000);
    step(40);
    chk("under_flag", underflow, 1);
    chk("req_held", rd_req, 1);
    ack_en = 1;
    step(20);
    pulse_nf(0);
    chk("uf_clear", underflow, 0);

    // Frame restart while a read is in WAIT
    n = 0;
    while (!(rd_req && rd_ack) && n < 100) begin step(1); n++; end
    if (n >= 100) chk("ack_timeout", n, 0);
    step(1);
    pulse_nf(0);
    step(12);
    chk("nf_wait_addr", log_at(0), 16384);
    run_to(0, 0, 0);  chk("nfw_px_0", pixel, 24'hffffff);
    run_to(14, 0, 0); chk("nfw_px_14", pixel, 24'h000000);
    run_to(16, 0, 0); chk("nfw_px_16", pixel, 24'h000000);
    run_to(40, 0, 0); chk("nfw_uf", underflow, 0);

    // Checkerboard test pattern, then back to memory data
    data_ones = 1; tst = 1;
    pulse_nf(1);
    chk("tp_0_0", pixel, 24'hffffff);
    run_to(8, 0, 0); chk("tp_8_0", pixel, 24'h000000);
    run_to(0, 8, 0); chk("tp_0_8", pixel, 24'h000000);
    run_to(8, 8, 0); chk("tp_8_8", pixel, 24'hffffff);
    chk("tp_uf", underflow, 0);
    tst = 0; #1;
    chk("tp_off_px", pixel, 24'h000000);

    // Enable toggling every cycle
    data_ones = 0;
    pulse_nf(0);
    step(12);
    run_to(14, 0, 1); chk("tg_px_14", pixel, 24'h000000);
    enable = 0;
    step(3);
    chk("tg_hold", pixel, 24'h000000);
    run_to(16, 0, 1); chk("tg_px_16", pixel, 24'h000000);
    run_to(17, 0, 1); chk("tg_px_17", pixel, 24'hffffff);
    run_to(100, 0, 1);
    chk("tg_uf", underflow, 0);
    chk("tg_addr0", log_at(0), 16384);
    chk("tg_addr1", log_at(1), 16385);
    chk("tg_addr2", log_at(2), 16386);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
